spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  SPI initiator for the SPI/RAM slave wrapper. Converts a parallel command request into a serial frame on SS_n/MOSI.
//  For READ_DATA it also captures the 8-bit reply from MISO.
//  Sits between a host sequencer/bus and the wrapper; clk is also the SPI bit clock (one bit per clk cycle).
// PARAMETERS
//  DATA_W      8  payload bits per frame and reply width
//  RD_LATENCY  2  idle SS_n-low cycles between last MOSI bit and first MISO bit (READ_DATA)
//  GAP_CYC     1  minimum SS_n-high cycles between frames (>=1)
// PORTS
//  clk        in   1       system/SPI clock, all logic on posedge
//  rst        in   1       asynchronous, active-high reset
//  req_valid  in   1       command request present
//  req_ready  out  1       controller can accept (high only in IDLE)
//  req_cmd    in   2       00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//  req_data   in   DATA_W  address/data payload
//  rsp_valid  out  1       one-cycle pulse: rsp_data valid (RD_DATA only)
//  rsp_data   out  DATA_W  byte read from MISO, held until next rsp_valid
//  req_err    out  1       one-cycle pulse: request dropped (see CONFIGURATION)
//  busy       out  1       high from accept until return to IDLE
//  SS_n       out  1       slave select, active low
//  MOSI       out  1       serial data to slave, MSB first
//  MISO       in   1       serial data from slave, sampled on posedge while in RECV
// BEHAVIOUR
//  Reset: state IDLE, SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_data=0, req_err=0.
//  Reset mid-frame aborts at once: SS_n=1, no rsp_valid for the aborted frame.
//  Accept on posedge with req_valid&&req_ready; req_cmd/req_data are captured into frame reg F={cmd,data}.
//  F is DATA_W+2 bits. Inputs are ignored outside accept.
//  FSM: IDLE -> SEND -> (RD_DATA ? WAIT -> RECV) -> GAP -> IDLE.
//  SEND: SS_n=0 for 1+DATA_W+2 cycles (11 at default).
//   Cycle 0 MOSI=cmd[1] (direction bit); cycles 1..DATA_W+2 MOSI=F MSB first.
//  WAIT: SS_n=0, MOSI=0 for RD_LATENCY cycles (0 => skip).
//  RECV: SS_n=0, MOSI=0, DATA_W cycles; MISO shifted into rx reg MSB first.
//  GAP: SS_n=1, MOSI=0 for GAP_CYC cycles.
//   On entry from RECV: rsp_data<=rx, rsp_valid=1 for exactly that cycle.
//  Write/RD_ADDR frame: SS_n low exactly 11 cycles. RD_DATA frame: 11+RD_LATENCY+8 cycles.
//  SS_n never glitches low outside SEND/WAIT/RECV. MOSI is 0 whenever SS_n=1.
//  Bit counter width $clog2(DATA_W+RD_LATENCY+3); it is reloaded on each state entry, with no wrap across states.
//  req_ready=0 during GAP, so back-to-back requests give exactly GAP_CYC high cycles.
//  req_valid high in the same cycle as the last GAP cycle is accepted on the next edge (IDLE).
// CONFIGURATION
//  SPI_MASTER_RD_ORDER_EN defined:
//   Internal flag rd_addr_pend is set by an accepted RD_ADDR and cleared by RD_DATA or reset.
//   RD_DATA accepted with rd_addr_pend=0 is dropped: no frame, SS_n stays 1, req_err pulses the cycle after accept.
//   The FSM then enters GAP.
//  Not defined: every command is framed; req_err tied 0; no rd_addr_pend flop.
// STRUCTURE
//  Package spi_pkg: cmd enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), state enum, FRAME_W=DATA_W+2 localparam.
//  The wrapper SVA/bench share spi_pkg.
//  One sub-module: spi_shift_reg (parallel load, MSB-first shift out, shift in, DATA_W+2 wide), used for TX and RX.
// TESTING
//  1 Reset: assert rst mid-SEND -> SS_n=1, MOSI=0, busy=0 same cycle; no rsp_valid.
//  2 WR_ADDR 0x5A -> SS_n low 11 cycles, MOSI=0,0,0,0,1,0,1,1,0,1,0; then SS_n high >=1 cycle.
//  3 WR_DATA 0x3C then RD_ADDR 0x5A back-to-back -> frames separated by exactly GAP_CYC high cycles.
//   MOSI first bits 0,0,1 then 1,1,0.
//  4 RD_DATA, slave drives 0xA5 after RD_LATENCY -> SS_n low 21 cycles; rsp_valid 1 cycle with rsp_data=0xA5.
//  5 req_valid held high continuously -> req_ready low while busy; no request lost or duplicated.
//  6 With SPI_MASTER_RD_ORDER_EN: RD_DATA before any RD_ADDR -> req_err pulse, SS_n stays 1.
//   Then RD_ADDR, RD_DATA -> normal read.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI initiator and the SPI/RAM slave wrapper bench/SVA.
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam int FRAME_W    = SPI_DATA_W + 2;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_e;
endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load / MSB-first shift register, used for both TX frame and RX byte.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sr_q;

  // load has priority over shift; shifting moves toward the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sr_q <= '0;
    else if (load_i)  sr_q <= load_val_i;
    else if (shift_i) sr_q <= {sr_q[W-2:0], sin_i};
  end

  assign q_o = sr_q;
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: turns a {cmd,data} request into an SS_n/MOSI frame and,
// for RD_DATA, captures the reply byte from MISO.
// Optional: SPI_MASTER_RD_ORDER_EN drops an RD_DATA not preceded by RD_ADDR.
// The single IDLE cycle in which the next request is accepted counts as the
// last SS_n-high gap cycle, so GAP holds for GAP_CYC-1 cycles after a frame.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W     = SPI_DATA_W,
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              req_err,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(DATA_W + RD_LATENCY + 3);
  localparam logic [CW-1:0] SEND_LD   = CW'(DATA_W + 2);
  localparam logic [CW-1:0] WAIT_LD   = CW'(RD_LATENCY - 1);
  localparam logic [CW-1:0] RECV_LD   = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LD_FR = CW'(GAP_CYC - 2);
  localparam logic [CW-1:0] GAP_LD_DR = CW'(GAP_CYC - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              ss_n_q, mosi_q, ready_q, busy_q, rsp_valid_q, rd_frame_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [FW-1:0]     tx_q, rx_q;
  logic              accept, drop;
  logic              unused_bits;

  assign accept = req_valid && ready_q;

  spi_shift_reg #(.W(FW)) u_tx (
    .clk(clk), .rst(rst),
    .load_i(accept && !drop), .load_val_i({req_cmd, req_data}),
    .shift_i((state_q == S_SEND) && (cnt_q != '0)), .sin_i(1'b0),
    .q_o(tx_q)
  );

  spi_shift_reg #(.W(FW)) u_rx (
    .clk(clk), .rst(rst),
    .load_i(1'b0), .load_val_i('0),
    .shift_i(state_q == S_RECV), .sin_i(MISO),
    .q_o(rx_q)
  );

  // only the TX MSB and the low RX bits carry data
  assign unused_bits = ^{tx_q[FW-2:0], rx_q[FW-1:DATA_W-1]};

`ifdef SPI_MASTER_RD_ORDER_EN
  logic rd_addr_pend_q, req_err_q;
  assign drop    = (req_cmd == RD_DATA) && !rd_addr_pend_q;
  assign req_err = req_err_q;

  // remember an outstanding RD_ADDR; flag an RD_DATA that arrives without one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_pend_q <= 1'b0;
      req_err_q      <= 1'b0;
    end else begin
      req_err_q <= accept && drop;
      if (accept && (req_cmd == RD_ADDR))      rd_addr_pend_q <= 1'b1;
      else if (accept && (req_cmd == RD_DATA)) rd_addr_pend_q <= 1'b0;
    end
  end
`else
  assign drop    = 1'b0;
  assign req_err = 1'b0;
`endif

  // frame sequencer; all pin-facing outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rd_frame_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          ready_q    <= 1'b0;
          busy_q     <= 1'b1;
          rd_frame_q <= (req_cmd == RD_DATA);
          if (drop) begin
            state_q <= S_GAP;
            cnt_q   <= GAP_LD_DR;
          end else begin
            state_q <= S_SEND;
            cnt_q   <= SEND_LD;
            ss_n_q  <= 1'b0;
            mosi_q  <= req_cmd[1];
          end
        end
        S_SEND: if (cnt_q != '0) begin
          mosi_q <= tx_q[FW-1];
          cnt_q  <= cnt_q - CW'(1);
        end else if (!rd_frame_q) begin
          ss_n_q <= 1'b1;
          mosi_q <= 1'b0;
          if (GAP_CYC > 1) begin
            state_q <= S_GAP;
            cnt_q   <= GAP_LD_FR;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end else if (RD_LATENCY > 0) begin
          state_q <= S_WAIT;
          cnt_q   <= WAIT_LD;
          mosi_q  <= 1'b0;
        end else begin
          state_q <= S_RECV;
          cnt_q   <= RECV_LD;
          mosi_q  <= 1'b0;
        end
        S_WAIT: if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          state_q <= S_RECV;
          cnt_q   <= RECV_LD;
        end
        S_RECV: if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= {rx_q[DATA_W-2:0], MISO};
          ss_n_q      <= 1'b1;
          if (GAP_CYC > 1) begin
            state_q <= S_GAP;
            cnt_q   <= GAP_LD_FR;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_GAP: if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed + randomized bench for spi_master_ctrl with a frame-level model.
module tb_spi_master_ctrl;
  localparam int DATA_W     = 8;
  localparam int RD_LATENCY = 2;
  localparam int GAP_CYC    = 1;
`ifdef SPI_MASTER_RD_ORDER_EN
  localparam bit ORDER = 1'b1;
`else
  localparam bit ORDER = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, MISO = 1'b0;
  logic [1:0]  req_cmd = 2'b00;
  logic [7:0]  req_data = 8'h00;
  logic        req_ready, rsp_valid, req_err, busy, SS_n, MOSI;
  logic [7:0]  rsp_data;

  int          checks = 0, errors = 0;
  bit          pend = 1'b0;
  logic [7:0]  exp_rsp = 8'h00;
  logic [10:0] last_word = '0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .req_err(req_err), .busy(busy), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // serial image of a request: direction bit, then cmd and data MSB first
  function automatic logic [10:0] ser_word(input logic [1:0] c, input logic [7:0] d);
    return {c[1], c, d};
  endfunction

  // issue one request from IDLE (called on a negedge) and check the whole frame
  task automatic do_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] mb);
    bit drop, rd;
    int n, w;
    logic [10:0] word, got;
    drop = ORDER && (c == 2'b11) && !pend;
    rd   = (c == 2'b11) && !drop;
    if (c == 2'b10) pend = 1'b1;
    else if (c == 2'b11) pend = 1'b0;
    word = ser_word(c, d);
    n    = rd ? 11 + RD_LATENCY + DATA_W : 11;
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_cmd = c; req_data = d;
    @(negedge clk);
    req_valid = 1'b0; req_cmd = 2'($urandom); req_data = 8'($urandom);
    if (drop) begin
      chk("drop_err", req_err, 1);
      chk("drop_ss", SS_n, 1);
    end else begin
      chk("c0_err", req_err, 0);
      chk("c0_busy", busy, 1);
      chk("c0_ready", req_ready, 0);
      got = '0;
      for (int i = 0; i < n; i++) begin
        chk("ss_low", SS_n, 0);
        chk("mosi", MOSI, (i < 11) ? word[10-i] : 1'b0);
        chk("rsp_quiet", rsp_valid, 0);
        if (i < 11) got[10-i] = MOSI;
        MISO = (i >= 11 + RD_LATENCY) ? mb[7-(i-11-RD_LATENCY)] : 1'b0;
        @(negedge clk);
      end
      MISO = 1'b0;
      last_word = got;
      if (rd) exp_rsp = mb;
      chk("end_ss", SS_n, 1);
      chk("end_mosi", MOSI, 0);
      chk("rsp_valid", rsp_valid, rd);
      chk("rsp_data", rsp_data, exp_rsp);
    end
    w = 0;
    while (!req_ready && w < 40) begin
      chk("gap_ss", SS_n, 1);
      chk("gap_mosi", MOSI, 0);
      @(negedge clk);
      w++;
    end
    chk("to_idle", req_ready, 1);
    // the accept cycle of the next request is the last high cycle
    if (!drop) chk("gap_hi", w + 1, GAP_CYC);
  endtask

  initial begin
    logic [10:0] items[$];
    logic [10:0] expq[$];
    logic        col[$];
    logic [10:0] v, ex;
    int          idx, frames;
    bit          hs, seen, low;

    // reset state
    @(negedge clk);
    chk("rst_ss", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_data, 0);
    chk("rst_err", req_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // fixed frames, back to back
    do_frame(2'b00, 8'h5A, 8'h00);
    chk("t2_bits", last_word, 11'b00001011010);
    do_frame(2'b01, 8'h3C, 8'h00);
    chk("t3a_first", last_word[10:8], 3'b001);
    do_frame(2'b10, 8'h5A, 8'h00);
    chk("t3b_first", last_word[10:8], 3'b110);
    do_frame(2'b11, 8'h00, 8'hA5);
    chk("t4_rsp", rsp_data, 8'hA5);

    // read ordering from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pend = 1'b0; exp_rsp = 8'h00;
    do_frame(2'b11, 8'h00, 8'hA5);
    chk("t6_err_idle", req_err, 0);
    do_frame(2'b10, 8'h42, 8'h00);
    do_frame(2'b11, 8'h42, 8'h3C);

    // random frames
    for (int k = 0; k < 12; k++)
      do_frame(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));

    // req_valid held high, next request presented after each handshake
    for (int k = 0; k < 8; k++)
      items.push_back(ser_word(2'($urandom_range(0, 2)), 8'($urandom)));
    idx = 0; frames = 0; hs = 1'b0;
    req_valid = 1'b1; req_cmd = items[0][9:8]; req_data = items[0][7:0];
    for (int cyc = 0; cyc < 400 && frames < 8; cyc++) begin
      if (!SS_n) col.push_back(MOSI);
      else if (col.size() != 0) begin
        chk("strm_len", col.size(), 11);
        v = '0;
        foreach (col[j]) v = {v[9:0], col[j]};
        ex = (expq.size() != 0) ? expq.pop_front() : 11'h7FF;
        chk("strm_word", v, ex);
        col.delete();
        frames++;
      end
      if (busy) chk("strm_rdy_busy", req_ready, 0);
      if (hs) begin
        idx++;
        if (idx < 8) begin req_cmd = items[idx][9:8]; req_data = items[idx][7:0]; end
        else req_valid = 1'b0;
      end
      hs = req_valid && req_ready;
      if (hs) begin
        expq.push_back(ser_word(req_cmd, req_data));
        if (req_cmd == 2'b10) pend = 1'b1;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("strm_frames", frames, 8);
    chk("strm_accepts", idx, 8);
    chk("strm_left", expq.size(), 0);
    repeat (GAP_CYC + 2) @(negedge clk);

    // reset in the middle of a read frame
    do_frame(2'b10, 8'h11, 8'h00);
    req_valid = 1'b1; req_cmd = 2'b11; req_data = 8'hC3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_ss", SS_n, 0);
    rst = 1'b1;
    #1;
    chk("abort_ss", SS_n, 1);
    chk("abort_mosi", MOSI, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_rspv", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0; pend = 1'b0;
    seen = 1'b0; low = 1'b0;
    repeat (30) begin
      if (rsp_valid) seen = 1'b1;
      if (!SS_n) low = 1'b1;
      MISO = 1'($urandom);
      @(negedge clk);
    end
    MISO = 1'b0;
    chk("abort_no_rsp", seen, 0);
    chk("abort_no_ss", low, 0);
    chk("abort_rspd", rsp_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
